// File: rtl/titan_pkg.sv
// Shared types and constants for the Titan fetch stage.
package titan_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    TRAP  = 2'd3
  } if_state_t;
endpackage

// File: rtl/titan_if_skid.sv
// Single-entry hold register that parks a fetched word while the decoder is stalled.
module titan_if_skid
  import titan_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            unload_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o,
  output logic            full_o
);
  logic [XLEN-1:0] data_q, data_d;
  logic            full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;
endmodule

// File: rtl/titan_if_stage.sv
// Instruction fetch stage: PC ownership, imem read requests, ID pipeline register.
// Define TITAN_IF_MISALIGN_EXC_EN to trap misaligned redirect targets instead of masking them.
module titan_if_stage #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = titan_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instruction_o,
  output logic        id_valid_o,
  output logic        id_exc_misalign_o
);
  import titan_pkg::*;

  // Bus handshake: imem_req_o rises with a stable imem_addr_o and both stay put
  // until the cycle imem_ack_i is high; that cycle transfers imem_data_i.
  if_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic        kill_q, kill_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic        id_exc_q, id_exc_d;
  logic        req;
  logic        skid_load, skid_unload, skid_full;
  logic [31:0] skid_data;
  logic [31:0] redirect_pc;

`ifdef TITAN_IF_MISALIGN_EXC_EN
  assign redirect_pc = branch_target_i;
`else
  assign redirect_pc = {branch_target_i[31:2], branch_target_i[1:0] & 2'b00};
`endif

  // A killed request keeps the bus busy even after the state has moved on.
  assign req = (state_q == FETCH) || kill_q;

  titan_if_skid u_skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .data_i   (imem_data_i),
    .data_o   (skid_data),
    .full_o   (skid_full)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    target_d    = target_q;
    kill_d      = kill_q;
    id_pc_d     = id_pc_q;
    id_instr_d  = id_instr_q;
    id_valid_d  = id_valid_q;
    id_exc_d    = id_exc_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    if (branch_taken_i) begin
      id_pc_d     = '0;
      id_instr_d  = NOP_INSTR;
      id_valid_d  = 1'b0;
      id_exc_d    = 1'b0;
      skid_unload = 1'b1;
      state_d     = FETCH;
      kill_d      = req && !imem_ack_i;
      // An in-flight request must finish on its old address; park the target.
      if (kill_d) target_d = redirect_pc;
      else        pc_d     = redirect_pc;
`ifdef TITAN_IF_MISALIGN_EXC_EN
      if (branch_target_i[1:0] != 2'b00) begin
        id_pc_d    = branch_target_i;
        id_valid_d = 1'b1;
        id_exc_d   = 1'b1;
        state_d    = TRAP;
      end
`endif
    end else if (kill_q && imem_ack_i) begin
      kill_d = 1'b0;
      pc_d   = target_q;
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (imem_ack_i) begin
            if (!stall_i) begin
              id_pc_d    = pc_q;
              id_instr_d = imem_data_i;
              id_valid_d = 1'b1;
              id_exc_d   = 1'b0;
              pc_d       = pc_q + 32'd4;
            end else begin
              skid_load = 1'b1;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_i && skid_full) begin
            id_pc_d     = pc_q;
            id_instr_d  = skid_data;
            id_valid_d  = 1'b1;
            id_exc_d    = 1'b0;
            pc_d        = pc_q + 32'd4;
            skid_unload = 1'b1;
            state_d     = FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_ADDR;
      target_q   <= RESET_ADDR;
      kill_q     <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      id_exc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      kill_q     <= kill_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      id_exc_q   <= id_exc_d;
    end
  end

  assign imem_req_o        = req;
  assign imem_addr_o       = pc_q;
  assign id_pc_o           = id_pc_q;
  assign id_instruction_o  = id_instr_q;
  assign id_valid_o        = id_valid_q;
  assign id_exc_misalign_o = id_exc_q;
endmodule
